// File: rtl/riscv_lsu.sv
// riscv_lsu: single-transaction load/store unit with byte lanes, extension and bus timeout.
// Optional `LSU_MISALIGN_EN: abort misaligned H/W accesses instead of truncating low address bits.
module riscv_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_err_o,
   output logic        core_misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic          we_q;
   logic [2:0]    size_q;
   logic [31:0]   addr_q;
   logic [31:0]   wd_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   rd_q;
   logic          err_q;
   logic          mis_q;

   logic in_b, in_h, in_w;
   logic size_ok, mis_hit, take;
   logic q_b, q_h;
   logic timeout;
   logic [31:0] rd_sh;
   logic [15:0] rd_half;
   logic [31:0] ld_ext;
   logic [3:0]  be;
   logic [31:0] wd_rep;

   assign in_b = (core_size_i == LDST_B) || (core_size_i == LDST_BU);
   assign in_h = (core_size_i == LDST_H) || (core_size_i == LDST_HU);
   assign in_w = (core_size_i == LDST_W);

   assign size_ok = core_we_i ? (core_size_i <= LDST_W) : (in_b | in_h | in_w);

`ifdef LSU_MISALIGN_EN
   assign mis_hit = size_ok & ((in_h & core_addr_i[0]) | (in_w & (|core_addr_i[1:0])));
`else
   assign mis_hit = 1'b0;
`endif

   assign take    = (state_q == S_IDLE) && core_req_i;
   assign timeout = (cnt_q == CNT_LAST);

   assign q_b = (size_q == LDST_B) || (size_q == LDST_BU);
   assign q_h = (size_q == LDST_H) || (size_q == LDST_HU);

   always_comb begin
      be     = 4'b1111;
      wd_rep = wd_q;
      unique case (1'b1)
         q_b: begin
            be     = 4'b0001 << addr_q[1:0];
            wd_rep = {4{wd_q[7:0]}};
         end
         q_h: begin
            be     = 4'b0011 << {addr_q[1], 1'b0};
            wd_rep = {2{wd_q[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection uses the latched address so the bus word can arrive late
   assign rd_sh   = mem_rd_i >> {addr_q[1:0], 3'b000};
   assign rd_half = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

   always_comb begin
      ld_ext = mem_rd_i;
      unique case (size_q)
         LDST_B:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
         LDST_BU: ld_ext = {24'b0, rd_sh[7:0]};
         LDST_H:  ld_ext = {{16{rd_half[15]}}, rd_half};
         LDST_HU: ld_ext = {16'b0, rd_half};
         default: ld_ext = mem_rd_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (core_req_i) begin
               state_d = (size_ok && !mis_hit) ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            if (mem_ready_i || timeout) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      core_stall_o = 1'b0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_be_o     = 4'b0;
      mem_addr_o   = 32'b0;
      mem_wd_o     = 32'b0;
      unique case (state_q)
         S_IDLE: core_stall_o = core_req_i;
         S_BUSY: begin
            core_stall_o = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = we_q;
            mem_be_o     = be;
            mem_addr_o   = {addr_q[31:2], 2'b00};
            mem_wd_o     = wd_rep;
         end
         S_DONE:  core_stall_o = 1'b0;
         default: core_stall_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q   <= 1'b0;
         size_q <= 3'b0;
         addr_q <= 32'b0;
         wd_q   <= 32'b0;
         cnt_q  <= '0;
         rd_q   <= 32'b0;
         err_q  <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         if (take) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            cnt_q  <= '0;
            rd_q   <= 32'b0;
            err_q  <= !size_ok || mis_hit;
            mis_q  <= mis_hit;
         end
         if (state_q == S_BUSY) begin
            if (mem_ready_i) begin
               rd_q <= we_q ? 32'b0 : ld_ext;
            end else begin
               cnt_q <= cnt_q + CW'(1);
               if (timeout) begin
                  rd_q  <= 32'b0;
                  err_q <= 1'b1;
               end
            end
         end
         if (state_q == S_DONE) begin
            err_q <= 1'b0;
            mis_q <= 1'b0;
         end
      end
   end

   assign core_rd_o       = rd_q;
   assign core_err_o      = err_q;
   assign core_misalign_o = mis_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed accesses checked against a lane-level model every cycle.
// Honours `LSU_MISALIGN_EN when the design is built with it.
module tb_riscv_lsu;

   localparam int T = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_req = 1'b0;
   logic        core_we = 1'b0;
   logic [2:0]  core_size = 3'd0;
   logic [31:0] core_addr = 32'd0;
   logic [31:0] core_wd = 32'd0;
   logic [31:0] core_rd;
   logic        core_stall;
   logic        core_err;
   logic        core_mis;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd = 32'd0;
   logic        mem_ready = 1'b0;

   riscv_lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .core_req_i(core_req), .core_we_i(core_we),
      .core_size_i(core_size), .core_addr_i(core_addr),
      .core_wd_i(core_wd), .core_rd_o(core_rd),
      .core_stall_o(core_stall), .core_err_o(core_err),
      .core_misalign_o(core_mis), .mem_req_o(mem_req),
      .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
      .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Model: byte lanes of a naturally sized access, extension by arithmetic
   function automatic void model(
      input  bit          we,
      input  logic [2:0]  sz,
      input  logic [31:0] a,
      input  logic [31:0] wd,
      input  logic [31:0] rdw,
      output bit          bus,
      output bit          mis,
      output logic [3:0]  be,
      output logic [31:0] ewd,
      output logic [31:0] erd
   );
      int n;
      int base;
      bit sgn;
      bit valid;
      longint val;
      n = 0;
      sgn = 1'b0;
      case (sz)
         3'd0: begin n = 1; sgn = 1'b1; end
         3'd1: begin n = 2; sgn = 1'b1; end
         3'd2: n = 4;
         3'd4: n = 1;
         3'd5: n = 2;
         default: n = 0;
      endcase
      valid = (n != 0) && !(we && sz > 3'd2);
      mis = 1'b0;
`ifdef LSU_MISALIGN_EN
      if (valid && n > 1 && (a % n) != 0) mis = 1'b1;
`endif
      bus = valid && !mis;
      base = (n == 0) ? 0 : ((int'(a % 4) / n) * n);
      be = 4'b0;
      ewd = 32'd0;
      for (int i = 0; i < 4; i++) begin
         be[i] = bus && (i >= base) && (i < base + n);
         if (n != 0) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
      end
      val = 0;
      for (int j = 0; j < n; j++) begin
         val = val + (longint'(rdw[8*(base+j) +: 8]) << (8*j));
      end
      if (n != 0 && sgn && val[8*n-1]) val = val - (longint'(1) << (8*n));
      erd = (bus && !we) ? val[31:0] : 32'd0;
   endfunction

   bit          active = 1'b0;
   int          c = 0;
   int          done_g = 0;
   bit          bus_g;
   logic        exp_req;
   logic [3:0]  exp_be;
   logic [31:0] exp_wd, exp_addr, exp_rd;
   logic        exp_we, exp_err, exp_mis;
   int          stall_cnt, req_cnt;
   logic [31:0] last_rd, obs_wd, obs_addr;
   logic        last_err, last_mis, obs_we;
   logic [3:0]  obs_be;

   always @(negedge clk) begin
      if (active) begin
         if (core_stall) stall_cnt++;
         if (mem_req) req_cnt++;
         exp_req = bus_g && (c >= 1) && (c < done_g);
         chk("stall", 32'(core_stall), 32'(c != done_g));
         chk("mem_req", 32'(mem_req), 32'(exp_req));
         if (exp_req) begin
            chk("mem_be", 32'(mem_be), 32'(exp_be));
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wd", mem_wd, exp_wd);
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            obs_be = mem_be;
            obs_wd = mem_wd;
            obs_addr = mem_addr;
            obs_we = mem_we;
         end
         if (c == done_g) begin
            chk("core_rd", core_rd, exp_rd);
            chk("core_err", 32'(core_err), 32'(exp_err));
            chk("core_mis", 32'(core_mis), 32'(exp_mis));
            last_rd = core_rd;
            last_err = core_err;
            last_mis = core_mis;
         end
      end else if (rst_n && !core_req) begin
         chk("idle_stall", 32'(core_stall), 32'd0);
         chk("idle_req", 32'(mem_req), 32'd0);
      end
   end

   // k = cycle (after request) on which mem_ready is raised; 0 = never
   task automatic run(input bit we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdw, input int k);
      bit mis;
      model(we, sz, a, wd, rdw, bus_g, mis, exp_be, exp_wd, exp_rd);
      exp_we = we;
      exp_addr = {a[31:2], 2'b00};
      exp_mis = mis;
      exp_err = !bus_g || (k == 0);
      if (k == 0) exp_rd = 32'd0;
      done_g = !bus_g ? 1 : ((k == 0) ? T + 1 : k + 1);
      stall_cnt = 0;
      req_cnt = 0;
      obs_be = 4'd0; obs_wd = 32'd0; obs_addr = 32'd0; obs_we = 1'b0;
      last_rd = 32'hx; last_err = 1'bx; last_mis = 1'bx;
      core_req = 1'b1;
      core_we = we;
      core_size = sz;
      core_addr = a;
      core_wd = wd;
      mem_rd = rdw;
      mem_ready = 1'b0;
      c = 0;
      active = 1'b1;
      while (c < done_g) begin
         @(posedge clk);
         #1;
         c++;
         mem_ready = (c == k);
      end
      @(posedge clk);
      #1;
      active = 1'b0;
      core_req = 1'b0;
      mem_ready = 1'b0;
   endtask

   initial begin
      #3;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wd", mem_wd, 32'd0);
      chk("rst_rd", core_rd, 32'd0);
      chk("rst_err", 32'({core_err, core_mis, mem_we}), 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 1);
      chk("t1_be", 32'(obs_be), 32'h8);
      chk("t1_rd", last_rd, 32'hFFFF_FF80);
      chk("t1_stall", stall_cnt, 2);

      run(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
      chk("t2_be", 32'(obs_be), 32'hC);
      chk("t2_wd", obs_wd, 32'hABCD_ABCD);
      chk("t2_addr", obs_addr, 32'h200);
      chk("t2_we", 32'(obs_we), 32'd1);
      chk("t2_rd", last_rd, 32'd0);

      run(1'b0, 3'd5, 32'h0, 32'd0, 32'h0000_9ABC, 4);
      chk("t3_stall", stall_cnt, 5);
      chk("t3_rd", last_rd, 32'h0000_9ABC);

      run(1'b0, 3'd2, 32'h10, 32'd0, 32'hDEAD_BEEF, 0);
      chk("t4_req", req_cnt, T);
      chk("t4_err", 32'(last_err), 32'd1);
      chk("t4_rd", last_rd, 32'd0);

      run(1'b0, 3'd2, 32'h6, 32'd0, 32'h1122_3344, 1);
`ifdef LSU_MISALIGN_EN
      chk("t5_req", req_cnt, 0);
      chk("t5_err", 32'({last_err, last_mis}), 32'h3);
`else
      chk("t5_addr", obs_addr, 32'h4);
      chk("t5_rd", last_rd, 32'h1122_3344);
`endif

      run(1'b0, 3'd0, 32'h101, 32'd0, 32'h0000_7F00, 2);
      chk("lb_pos", last_rd, 32'h0000_007F);
      run(1'b0, 3'd4, 32'h102, 32'd0, 32'h0080_0000, 1);
      chk("lbu", last_rd, 32'h0000_0080);
      run(1'b0, 3'd1, 32'h2, 32'd0, 32'h8001_1234, 3);
      chk("lh_neg", last_rd, 32'hFFFF_8001);
      run(1'b1, 3'd0, 32'h3, 32'h0000_00AA, 32'd0, 1);
      chk("sb_wd", obs_wd, 32'hAAAA_AAAA);
      run(1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, 32'd0, 2);
      run(1'b0, 3'd1, 32'h3, 32'd0, 32'hA5B6_C7D8, 1);
      run(1'b0, 3'd2, 32'h4, 32'd0, 32'h0BAD_F00D, T);
      chk("ready_at_timeout_err", 32'(last_err), 32'd0);
      run(1'b0, 3'd3, 32'h8, 32'd0, 32'd0, 1);
      chk("bad_ld_req", req_cnt, 0);
      run(1'b1, 3'd4, 32'h8, 32'h55, 32'd0, 1);
      chk("bad_st_err", 32'(last_err), 32'd1);

      core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h20;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t6_busy", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req_drop", 32'(mem_req), 32'd0);
      chk("t6_be_drop", 32'(mem_be), 32'd0);
      core_req = 1'b0;
      #1;
      chk("t6_stall_rst", 32'(core_stall), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_stall", 32'(core_stall), 32'd0);
      chk("t6_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
